// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and helpers shared by the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned CntW = 10;
  localparam int unsigned MaxTotal = 1 << CntW;

  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;

  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  localparam int unsigned DefHTotal = DefHVisible + DefHFront + DefHSync + DefHBack;
  localparam int unsigned DefVTotal = DefVVisible + DefVFront + DefVSync + DefVBack;

  localparam int unsigned DefHSyncStart = DefHVisible + DefHFront;
  localparam int unsigned DefHSyncEnd   = DefHSyncStart + DefHSync;
  localparam int unsigned DefVSyncStart = DefVVisible + DefVFront;
  localparam int unsigned DefVSyncEnd   = DefVSyncStart + DefVSync;

  // True when lo <= cnt < lo + len.
  function automatic logic in_window(int unsigned cnt, int unsigned lo, int unsigned len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated DEPTH x WIDTH shift register with a per-bit reset value; Depth 0 is a wire.
module vga_sync_delay #(
  parameter int unsigned     Depth    = 1,
  parameter int unsigned     Width    = 3,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) begin
          stage_q[i] <= ResetVal;
        end
      end else if (en_i) begin
        for (int i = 0; i < Depth; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank decode (delayed to align with the drawers' RGB stage) and
// frame/line markers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DefHVisible,
  parameter int unsigned H_FRONT    = DefHFront,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BACK     = DefHBack,
  parameter int unsigned V_VISIBLE  = DefVVisible,
  parameter int unsigned V_FRONT    = DefVFront,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BACK     = DefVBack,
  parameter int unsigned SYNC_DELAY = 1,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               pix_en,
  output logic [CntW-1:0]    DrawX,
  output logic [CntW-1:0]    DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;

  localparam logic [CntW-1:0] HMax = CntW'(H_TOTAL - 1);
  localparam logic [CntW-1:0] VMax = CntW'(V_TOTAL - 1);

  if (H_TOTAL > MaxTotal || V_TOTAL > MaxTotal) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", MaxTotal);
  end
  if (SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  logic [CntW-1:0]    hc_q, hc_d;
  logic [CntW-1:0]    vc_q, vc_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (hc_q == HMax) begin
        hc_d = '0;
        if (vc_q == VMax) begin
          vc_d    = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          vc_d = vc_q + CntW'(1);
        end
      end else begin
        hc_d = hc_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
    end
  end

  // Decode in 32-bit space so window ends at the counter limit cannot overflow.
  logic [31:0] hc_ext, vc_ext;
  logic        blank_raw, hs_raw, vs_raw;

  always_comb begin
    hc_ext    = 32'(hc_q);
    vc_ext    = 32'(vc_q);
    blank_raw = (hc_ext < H_VISIBLE) && (vc_ext < V_VISIBLE);
    hs_raw    = !in_window(hc_ext, HSyncStart, H_SYNC);
    vs_raw    = !in_window(vc_ext, VSyncStart, V_SYNC);
  end

  // Reset value keeps the monitor pins inactive until real decode values arrive.
  vga_sync_delay #(
    .Depth   (SYNC_DELAY),
    .Width   (3),
    .ResetVal(3'b110)
  ) u_sync_delay (
    .clk_i (vga_clk),
    .rst_ni(reset_n),
    .en_i  (pix_en),
    .d_i   ({hs_raw, vs_raw, blank_raw}),
    .q_o   ({hs, vs, blank})
  );

  always_comb begin
    DrawX       = hc_q;
    DrawY       = vc_q;
    line_start  = (hc_q == '0);
    frame_start = (hc_q == '0) && (vc_q == '0);
    frame_count = frame_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus a shrunken raster (25x15) at delays 0, 1 and 3.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en  = 1'b1;

  always #5 vga_clk = ~vga_clk;

  // Default timing, SYNC_DELAY 1, FRAME_W 8.
  logic [9:0] d_x, d_y;
  logic       d_blank, d_hs, d_vs, d_ls, d_fs;
  logic [7:0] d_fc;

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(d_x), .DrawY(d_y), .blank(d_blank), .hs(d_hs), .vs(d_vs),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  // Small raster: H 16/2/4/3 (25), V 8/2/2/3 (15), 375 cycles per frame.
  logic [9:0] s1_x, s1_y, s0_x, s0_y, s3_x, s3_y;
  logic       s1_blank, s1_hs, s1_vs, s1_ls, s1_fs;
  logic       s0_blank, s0_hs, s0_vs, s0_ls, s0_fs;
  logic       s3_blank, s3_hs, s3_vs, s3_ls, s3_fs;
  logic [1:0] s1_fc, s0_fc, s3_fc;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(1), .FRAME_W(2)
  ) u_s1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s1_x), .DrawY(s1_y), .blank(s1_blank), .hs(s1_hs), .vs(s1_vs),
    .line_start(s1_ls), .frame_start(s1_fs), .frame_count(s1_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(0), .FRAME_W(2)
  ) u_s0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s0_x), .DrawY(s0_y), .blank(s0_blank), .hs(s0_hs), .vs(s0_vs),
    .line_start(s0_ls), .frame_start(s0_fs), .frame_count(s0_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(3), .FRAME_W(2)
  ) u_s3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s3_x), .DrawY(s3_y), .blank(s3_blank), .hs(s3_hs), .vs(s3_vs),
    .line_start(s3_ls), .frame_start(s3_fs), .frame_count(s3_fc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: posedge then sample on the following negedge.
  task automatic tick();
    @(posedge vga_clk);
    @(negedge vga_clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset_n = 1'b0;
    pix_en  = 1'b1;
    @(negedge vga_clk);
    reset_n = 1'b1;
    cyc     = 0;
    #1;
  endtask

  typedef struct {
    int n;
    int x;
    int y;
    bit hs;
    bit blank;
    bit ls;
    bit fs;
  } vec_t;

  vec_t vecs[13];

  int   s0_hs_fall, s1_hs_fall, s3_hs_fall, s0_hs_rise, s1_hs_rise, s3_hs_rise;
  int   s0_bl_fall, s1_bl_fall, s3_bl_fall, s1_vs_fall, s1_vs_low, fs_pulses, hs_low_clks;
  int   hold_bad;
  logic p_s0_hs, p_s1_hs, p_s3_hs, p_s0_bl, p_s1_bl, p_s3_bl, p_s1_vs;
  logic [31:0] snap;

  initial begin
    // n, DrawX, DrawY, hs, blank, line_start, frame_start for the default-timing instance.
    vecs[0]  = '{0,   0,   0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{639, 639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{640, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{641, 641, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{656, 656, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{657, 657, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{752, 752, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{753, 753, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{799, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{800, 0,   1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{801, 1,   1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1600, 0,  2, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state, checked while reset_n is still low.
    @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    check("rst_drawx", d_x, 0);
    check("rst_drawy", d_y, 0);
    check("rst_hs", d_hs, 1);
    check("rst_vs", d_vs, 1);
    check("rst_blank", d_blank, 0);
    check("rst_fc", d_fc, 0);
    check("rst_fs", d_fs, 1);

    // Table-driven walk along the first lines of the default raster.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      while (cyc < vecs[i].n) tick();
      check($sformatf("v%0d_drawx", i), d_x, vecs[i].x);
      check($sformatf("v%0d_drawy", i), d_y, vecs[i].y);
      check($sformatf("v%0d_hs", i), d_hs, vecs[i].hs);
      check($sformatf("v%0d_blank", i), d_blank, vecs[i].blank);
      check($sformatf("v%0d_ls", i), d_ls, vecs[i].ls);
      check($sformatf("v%0d_fs", i), d_fs, vecs[i].fs);
      check($sformatf("v%0d_vs", i), d_vs, 1);
    end

    // Small raster: edge alignment across delays, vsync width, frame counting and wrap.
    do_reset();
    s0_hs_fall = -1; s1_hs_fall = -1; s3_hs_fall = -1;
    s0_hs_rise = -1; s1_hs_rise = -1; s3_hs_rise = -1;
    s0_bl_fall = -1; s1_bl_fall = -1; s3_bl_fall = -1;
    s1_vs_fall = -1; s1_vs_low = 0; fs_pulses = 0;
    p_s0_hs = s0_hs; p_s1_hs = s1_hs; p_s3_hs = s3_hs;
    p_s0_bl = s0_blank; p_s1_bl = s1_blank; p_s3_bl = s3_blank; p_s1_vs = s1_vs;
    if (s1_fs) fs_pulses++;
    if (!s1_vs) s1_vs_low++;
    while (cyc < 1875) begin
      tick();
      if (cyc < 375) begin
        if (p_s0_hs && !s0_hs && s0_hs_fall < 0) s0_hs_fall = cyc;
        if (p_s1_hs && !s1_hs && s1_hs_fall < 0) s1_hs_fall = cyc;
        if (p_s3_hs && !s3_hs && s3_hs_fall < 0) s3_hs_fall = cyc;
        if (!p_s0_hs && s0_hs && s0_hs_rise < 0) s0_hs_rise = cyc;
        if (!p_s1_hs && s1_hs && s1_hs_rise < 0) s1_hs_rise = cyc;
        if (!p_s3_hs && s3_hs && s3_hs_rise < 0) s3_hs_rise = cyc;
        if (p_s0_bl && !s0_blank && s0_bl_fall < 0) s0_bl_fall = cyc;
        if (p_s1_bl && !s1_blank && s1_bl_fall < 0) s1_bl_fall = cyc;
        if (p_s3_bl && !s3_blank && s3_bl_fall < 0) s3_bl_fall = cyc;
        if (p_s1_vs && !s1_vs && s1_vs_fall < 0) s1_vs_fall = cyc;
        if (!s1_vs) s1_vs_low++;
      end
      if (cyc <= 1125 && s1_fs) fs_pulses++;
      if (cyc == 25) begin
        check("s1_wrap_x", s1_x, 0);
        check("s1_wrap_y", s1_y, 1);
      end
      if (cyc == 1125) check("s1_fc_3frames", s1_fc, 3);
      if (cyc == 1500) check("s1_fc_wrap", s1_fc, 0);
      p_s0_hs = s0_hs; p_s1_hs = s1_hs; p_s3_hs = s3_hs;
      p_s0_bl = s0_blank; p_s1_bl = s1_blank; p_s3_bl = s3_blank; p_s1_vs = s1_vs;
    end
    check("s0_hs_fall", s0_hs_fall, 18);
    check("s1_hs_fall", s1_hs_fall, 19);
    check("s3_hs_fall", s3_hs_fall, 21);
    check("s0_hs_rise", s0_hs_rise, 22);
    check("s1_hs_rise", s1_hs_rise, 23);
    check("s3_hs_rise", s3_hs_rise, 25);
    check("s0_blank_fall", s0_bl_fall, 16);
    check("s1_blank_fall", s1_bl_fall, 17);
    check("s3_blank_fall", s3_bl_fall, 19);
    check("s1_vs_fall", s1_vs_fall, 251);
    check("s1_vs_low_cycles", s1_vs_low, 50);
    check("s1_fs_pulses", fs_pulses, 4);
    check("s1_fc_5frames", s1_fc, 1);
    check("s0_fc_5frames", s0_fc, 1);

    // pix_en alternating 1,0,...: half-rate advance, holds on idle cycles, doubled hs width.
    do_reset();
    hs_low_clks = 0;
    hold_bad    = 0;
    for (int k = 0; k < 1700; k++) begin
      pix_en = (k % 2 == 0);
      #1;
      snap = {d_x, d_y, d_hs, d_vs, d_blank, d_fc[0], s1_x[5:0], s1_hs, s1_vs};
      tick();
      if (!pix_en && snap != {d_x, d_y, d_hs, d_vs, d_blank, d_fc[0], s1_x[5:0], s1_hs, s1_vs})
        hold_bad++;
      if (!d_hs) hs_low_clks++;
      if (k == 1599) begin
        check("half_rate_drawx", d_x, 0);
        check("half_rate_drawy", d_y, 1);
      end
    end
    check("stall_hold_errs", hold_bad, 0);
    check("hs_low_clocks", hs_low_clks, 192);

    // Asynchronous reset in the middle of hsync/vsync on the small raster.
    do_reset();
    while (cyc < 270) tick();
    check("pre_rst_x", s1_x, 20);
    check("pre_rst_y", s1_y, 10);
    check("pre_rst_hs", s1_hs, 0);
    check("pre_rst_vs", s1_vs, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_x", s1_x, 0);
    check("mid_rst_y", s1_y, 0);
    check("mid_rst_hs", s1_hs, 1);
    check("mid_rst_vs", s1_vs, 1);
    check("mid_rst_blank", s1_blank, 0);
    check("mid_rst_s3_hs", s3_hs, 1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    cyc     = 0;
    #1;
    check("rel_s1_blank_n0", s1_blank, 0);
    tick();
    check("rel_s1_blank_n1", s1_blank, 1);
    check("rel_s1_x_n1", s1_x, 1);
    tick();
    check("rel_s3_blank_n2", s3_blank, 0);
    tick();
    check("rel_s3_blank_n3", s3_blank, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
